bitblaster_core: RTL

- Parametrised successor to the fixed 10-bit Bitblaster datapath/controller.
- Multi-cycle core containing:
  - timestep sequencer
  - instruction register
  - NREGS x DATA_W register file
  - A/G staged ALU
  - synchronous-RAM master port
- Instructions arrive over a valid/ready handshake. RAM load/store, an illegal-opcode flag and a debug read port are added.
- Sits under the board top level, between input logic (switches/debounce) and output logic (LEDs/hex).

---
 rtl/bitblaster_pkg.sv | 54 +++++
 rtl/bitblaster_alu.sv | 58 +++++
 rtl/bitblaster_core.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bitblaster_pkg.sv
// Shared types for the Bitblaster core: opcode/class/timestep
// enums, the instruction word layout and decode helpers.
package bitblaster_pkg;

    localparam int INST_W = 10;
    localparam int IMM_W  = 6;

    typedef enum logic [3:0] {
        FN_LD  = 4'b0000,
        FN_CP  = 4'b0001,
        FN_ADD = 4'b0010,
        FN_SUB = 4'b0011,
        FN_INV = 4'b0100,
        FN_FLP = 4'b0101,
        FN_AND = 4'b0110,
        FN_OR  = 4'b0111,
        FN_XOR = 4'b1000,
        FN_LSL = 4'b1001,
        FN_LSR = 4'b1010,
        FN_ASR = 4'b1011,
        FN_LDR = 4'b1100,
        FN_STR = 4'b1101,
        FN_IL0 = 4'b1110,
        FN_IL1 = 4'b1111
    } fn_e;

    typedef enum logic [1:0] {
        CL_REG  = 2'b00,
        CL_ILL  = 2'b01,
        CL_ADDI = 2'b10,
        CL_SUBI = 2'b11
    } cls_e;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } ts_e;

    // Immediate forms reuse the ry/fn bits as a 6-bit literal.
    typedef struct packed {
        cls_e       cls;
        logic [1:0] rx;
        logic [1:0] ry;
        fn_e        fn;
    } inst_t;

    function automatic logic is_illegal(input inst_t i);
        return (i.cls == CL_ILL) ||
               ((i.cls == CL_REG) && (i.fn inside {FN_IL0, FN_IL1}));
    endfunction

endpackage

// File: rtl/bitblaster_alu.sv
// A/G staged ALU: A holds the first operand, G captures the
// function result for write-back on the following step.
import bitblaster_pkg::*;

module bitblaster_alu #(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_in,
    input  logic              g_in,
    input  fn_e               fn,
    input  logic [DATA_W-1:0] bus,
    input  logic [DATA_W-1:0] opnd,
    output logic [DATA_W-1:0] g
);

    localparam logic [DATA_W-1:0] W_LIM = DATA_W'(DATA_W);

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] g_q;
    logic [DATA_W-1:0] res;
    logic              big;

    assign big = (opnd >= W_LIM);

    always_comb begin
        res = '0;
        case (fn)
            FN_ADD: res = a_q + opnd;
            FN_SUB: res = a_q - opnd;
            FN_INV: res = '0 - opnd;
            FN_FLP: res = ~opnd;
            FN_AND: res = a_q & opnd;
            FN_OR:  res = a_q | opnd;
            FN_XOR: res = a_q ^ opnd;
            FN_LSL: res = big ? '0 : (a_q << opnd);
            FN_LSR: res = big ? '0 : (a_q >> opnd);
            // Oversized arithmetic shifts saturate to the sign fill.
            FN_ASR: res = big ? {DATA_W{a_q[DATA_W-1]}}
                              : ($signed(a_q) >>> opnd);
            default: res = '0;
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            a_q <= '0;
            g_q <= '0;
        end else begin
            if (a_in) a_q <= bus;
            if (g_in) g_q <= res;
        end
    end

    assign g = g_q;

endmodule

// File: rtl/bitblaster_core.sv
// Bitblaster core: T0..T3 sequencer, instruction register,
// register file and RAM master port around the A/G ALU.
import bitblaster_pkg::*;

module bitblaster_core #(
    parameter int DATA_W = 10,
    parameter int NREGS  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              CLKb,
    input  logic              reset,
    input  logic [9:0]        inst,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [DATA_W-1:0] ext_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [1:0]        timestep,
    output logic              done,
    output logic              err
);

    if (NREGS != 4) begin : g_nregs_chk
        $error("bitblaster_core: NREGS must be 4");
    end
    if (DATA_W < 10 || DATA_W > 32) begin : g_dw_chk
        $error("bitblaster_core: DATA_W must be 10..32");
    end
    if (ADDR_W > DATA_W) begin : g_aw_chk
        $error("bitblaster_core: ADDR_W must not exceed DATA_W");
    end

    ts_e               ts_q;
    ts_e               ts_d;
    inst_t             ir_q;
    logic [DATA_W-1:0] regs_q [NREGS];

    logic              ir_ld;
    logic              reg_we;
    logic [DATA_W-1:0] reg_wdata;
    logic              a_in;
    logic              g_in;
    logic [DATA_W-1:0] rx_val;
    logic [DATA_W-1:0] ry_val;
    logic [DATA_W-1:0] imm_val;
    logic [DATA_W-1:0] alu_opnd;
    logic [DATA_W-1:0] g_val;
    fn_e               alu_fn;

    logic is_imm;
    logic op_ill;
    logic op_ld;
    logic op_cp;
    logic op_un;
    logic op_ldr;
    logic op_str;
    logic op_alu;

    assign rx_val  = regs_q[ir_q.rx];
    assign ry_val  = regs_q[ir_q.ry];
    assign imm_val = DATA_W'(ir_q[IMM_W-1:0]);

    assign is_imm = ir_q.cls inside {CL_ADDI, CL_SUBI};
    assign op_ill = is_illegal(ir_q);
    assign op_ld  = (ir_q.cls == CL_REG) && (ir_q.fn == FN_LD);
    assign op_cp  = (ir_q.cls == CL_REG) && (ir_q.fn == FN_CP);
    assign op_un  = (ir_q.cls == CL_REG) &&
                    (ir_q.fn inside {FN_INV, FN_FLP});
    assign op_ldr = (ir_q.cls == CL_REG) && (ir_q.fn == FN_LDR);
    assign op_str = (ir_q.cls == CL_REG) && (ir_q.fn == FN_STR);
    assign op_alu = is_imm || ((ir_q.cls == CL_REG) &&
                    (ir_q.fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR,
                                     FN_XOR, FN_LSL, FN_LSR, FN_ASR}));

    assign alu_fn   = !is_imm ? ir_q.fn :
                      (ir_q.cls == CL_ADDI) ? FN_ADD : FN_SUB;
    assign alu_opnd = is_imm ? imm_val : ry_val;

    always_comb begin
        ts_d       = ts_q;
        inst_ready = 1'b0;
        ir_ld      = 1'b0;
        reg_we     = 1'b0;
        reg_wdata  = '0;
        a_in       = 1'b0;
        g_in       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        mem_rd     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (ts_q)
            T0: begin
                inst_ready = 1'b1;
                if (inst_valid) begin
                    ir_ld = 1'b1;
                    ts_d  = T1;
                end
            end
            T1: begin
                ts_d = T0;
                unique case (1'b1)
                    op_ill: err = 1'b1;
                    op_ld: begin
                        reg_we    = 1'b1;
                        reg_wdata = ext_data;
                        done      = 1'b1;
                    end
                    op_cp: begin
                        reg_we    = 1'b1;
                        reg_wdata = ry_val;
                        done      = 1'b1;
                    end
                    op_un: begin
                        g_in = 1'b1;
                        ts_d = T2;
                    end
                    op_alu: begin
                        a_in = 1'b1;
                        ts_d = T2;
                    end
                    op_ldr: begin
                        mem_rd   = 1'b1;
                        mem_addr = ry_val[ADDR_W-1:0];
                        ts_d     = T2;
                    end
                    op_str: begin
                        mem_we    = 1'b1;
                        mem_addr  = ry_val[ADDR_W-1:0];
                        mem_wdata = rx_val;
                        done      = 1'b1;
                    end
                    default: ts_d = T0;
                endcase
            end
            T2: begin
                ts_d = T0;
                unique case (1'b1)
                    op_un: begin
                        reg_we    = 1'b1;
                        reg_wdata = g_val;
                        done      = 1'b1;
                    end
                    op_alu: begin
                        g_in = 1'b1;
                        ts_d = T3;
                    end
                    op_ldr: begin
                        reg_we    = 1'b1;
                        reg_wdata = mem_rdata;
                        done      = 1'b1;
                    end
                    default: ts_d = T0;
                endcase
            end
            T3: begin
                reg_we    = 1'b1;
                reg_wdata = g_val;
                done      = 1'b1;
                ts_d      = T0;
            end
        endcase
        // A reset edge must not let a pending store reach the RAM.
        if (reset) begin
            mem_we = 1'b0;
            mem_rd = 1'b0;
            done   = 1'b0;
            err    = 1'b0;
        end
    end

    always_ff @(negedge CLKb) begin
        if (reset) begin
            ts_q <= T0;
            ir_q <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            ts_q <= ts_d;
            if (ir_ld)  ir_q <= inst_t'(inst);
            if (reg_we) regs_q[ir_q.rx] <= reg_wdata;
        end
    end

    bitblaster_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .clk  (CLKb),
        .reset(reset),
        .a_in (a_in),
        .g_in (g_in),
        .fn   (alu_fn),
        .bus  (rx_val),
        .opnd (alu_opnd),
        .g    (g_val)
    );

    assign dbg_data = regs_q[dbg_addr];
    assign timestep = ts_q;

endmodule
